// File: rtl/seg_pkg.sv
// Shared 7-segment glyph definitions (bit 0 = segment a ... bit 6 = segment g).
// All patterns are active-high; polarity is applied by the display driver.
package seg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h58;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Hex nibble to segment pattern: A, b, c, d, E, F for the letters.
  function automatic logic [6:0] glyph(input logic [3:0] nibble);
    logic [6:0] pat;
    pat = SEG_OFF;
    case (nibble)
      4'h0: pat = GLYPH_0;
      4'h1: pat = GLYPH_1;
      4'h2: pat = GLYPH_2;
      4'h3: pat = GLYPH_3;
      4'h4: pat = GLYPH_4;
      4'h5: pat = GLYPH_5;
      4'h6: pat = GLYPH_6;
      4'h7: pat = GLYPH_7;
      4'h8: pat = GLYPH_8;
      4'h9: pat = GLYPH_9;
      4'hA: pat = GLYPH_A;
      4'hB: pat = GLYPH_B;
      4'hC: pat = GLYPH_C;
      4'hD: pat = GLYPH_D;
      4'hE: pat = GLYPH_E;
      4'hF: pat = GLYPH_F;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Bundle between the value-producing logic and the scanned display driver.
// master: the logic supplying digits; slave: the display driver.
interface seg_scan_if #(
  parameter int DIGITS = 4
) ();

  logic [4*DIGITS-1:0] number;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank;
  logic                lz_en;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame;

  modport master (
    output number, dp_in, blank, lz_en,
    input  seg, dp, an, frame
  );

  modport slave (
    input  number, dp_in, blank, lz_en,
    output seg, dp, an, frame
  );

endinterface

// File: rtl/seg_scan_timer.sv
// Slot timing for the scanned display: a cycle counter per digit slot and
// the digit index it advances. Flags the guard window at the start of each
// slot and the last cycle of the last slot, where shadows get captured.
module seg_scan_timer #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  localparam int CW = $clog2(REFRESH_DIV),
  localparam int IW = $clog2(DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [IW-1:0] idx,
  output logic          in_guard,
  output logic          frame_cap
);

  logic [CW-1:0] cnt;
  logic          slot_end;
  logic          last_digit;

  assign slot_end   = (cnt == CW'(REFRESH_DIV - 1));
  assign last_digit = (idx == IW'(DIGITS - 1));
  assign in_guard   = (cnt < CW'(GUARD));
  assign frame_cap  = slot_end && last_digit;

  // Advance the slot counter each cycle; step the digit index on slot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= last_digit ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed hex display driver. Inputs are captured into shadow
// registers once per full scan so a frame never mixes old and new values;
// the lit digit, glyph and decimal point are registered before the pins.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  seg_scan_if.slave bus
);

  localparam int IW = $clog2(DIGITS);
  localparam logic [6:0]        SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_INV  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_INV  = AN_ACTIVE_LOW ? '1 : '0;

  logic [IW-1:0]       idx;
  logic                in_guard;
  logic                frame_cap;

  logic [4*DIGITS-1:0] sh_num;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic                sh_lz;

  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   suppress;
  logic                tail_zero;
  logic                lit;
  logic [DIGITS-1:0]   an_nx;
  logic [6:0]          seg_nx;
  logic                dp_nx;

  seg_scan_timer #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .in_guard  (in_guard),
    .frame_cap (frame_cap)
  );

  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    assign nib[g] = sh_num[4*g +: 4];
  end

  // Capture all display inputs together at the end of each full scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_num   <= '0;
      sh_dp    <= '0;
      sh_blank <= '1;
      sh_lz    <= 1'b0;
    end else if (frame_cap) begin
      sh_num   <= bus.number;
      sh_dp    <= bus.dp_in;
      sh_blank <= bus.blank;
      sh_lz    <= bus.lz_en;
    end
  end

  // A digit is a leading zero when it and every digit above it are 0 without dp.
  always_comb begin
    suppress  = '0;
    tail_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      tail_zero = tail_zero && (nib[i] == 4'h0) && !sh_dp[i];
      if (i > 0) suppress[i] = sh_lz && tail_zero;
    end
  end

  // Select what the current slot shows; dark during guard, blank or suppression.
  always_comb begin
    lit    = !in_guard && !sh_blank[idx] && !suppress[idx];
    an_nx  = '0;
    seg_nx = SEG_OFF;
    dp_nx  = 1'b0;
    if (lit) begin
      an_nx[idx] = 1'b1;
      seg_nx     = glyph(nib[idx]);
      dp_nx      = sh_dp[idx];
    end
  end

  // Register the pin levels with board polarity and emit the capture pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg   <= SEG_INV;
      bus.dp    <= DP_INV;
      bus.an    <= AN_INV;
      bus.frame <= 1'b0;
    end else begin
      bus.seg   <= seg_nx ^ SEG_INV;
      bus.dp    <= dp_nx ^ DP_INV;
      bus.an    <= an_nx ^ AN_INV;
      bus.frame <= frame_cap;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan with 4 digits, 8-cycle slots, 2-cycle guard, active-low
// pins. A cycle-count model predicts every output after every clock edge.
module tb_seg_scan;

  localparam int D = 4;
  localparam int R = 8;
  localparam int G = 2;
  localparam int FRAME_LEN = D * R;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [15:0] m_num;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic        m_lz;

  logic [6:0] glyph_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  seg_scan_if #(.DIGITS(D)) bus ();

  seg_scan #(
    .DIGITS         (D),
    .REFRESH_DIV    (R),
    .GUARD          (G),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] n, input logic [3:0] d,
                               input logic [3:0] b, input logic lz);
    bus.number = n;
    bus.dp_in  = d;
    bus.blank  = b;
    bus.lz_en  = lz;
  endtask

  task automatic modelReset();
    m_num   = 16'h0000;
    m_dp    = 4'h0;
    m_blank = 4'hF;
    m_lz    = 1'b0;
    cyc     = 0;
  endtask

  // One clock: predict what cycle cyc shows, then compare after the edge.
  task automatic clockStep();
    int slot;
    int phase;
    bit supp;
    bit lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_frame;
    slot  = (cyc / R) % D;
    phase = cyc % R;
    supp  = 1'b0;
    if (m_lz && slot > 0) begin
      supp = 1'b1;
      for (int j = slot; j < D; j++)
        if (m_num[4*j +: 4] != 4'h0 || m_dp[j]) supp = 1'b0;
    end
    lit     = (phase >= G) && !m_blank[slot] && !supp;
    e_an    = lit ? ~(4'b0001 << slot) : 4'hF;
    e_seg   = lit ? ~glyph_tab[m_num[4*slot +: 4]] : 7'h7F;
    e_dp    = lit ? ~m_dp[slot] : 1'b1;
    e_frame = (cyc % FRAME_LEN) == FRAME_LEN - 1;
    if (e_frame) begin
      m_num   = bus.number;
      m_dp    = bus.dp_in;
      m_blank = bus.blank;
      m_lz    = bus.lz_en;
    end
    @(posedge clk);
    #1;
    cyc++;
    checkOutput("an", 32'(bus.an), 32'(e_an));
    checkOutput("seg", 32'(bus.seg), 32'(e_seg));
    checkOutput("dp", 32'(bus.dp), 32'(e_dp));
    checkOutput("frame", 32'(bus.frame), 32'(e_frame));
    checkOutput("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) clockStep();
  endtask

  initial begin
    applyStimulus(16'h1234, 4'h0, 4'h0, 1'b0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_an", 32'(bus.an), 32'h0000000F);
    checkOutput("reset_seg", 32'(bus.seg), 32'h0000007F);
    checkOutput("reset_dp", 32'(bus.dp), 32'd1);
    checkOutput("reset_frame", 32'(bus.frame), 32'd0);
    rst_n = 1'b1;

    // Dark for a full scan, frame pulse, then 4,3,2,1 on the next scan.
    runCycles(FRAME_LEN);
    checkOutput("first_frame", 32'(bus.frame), 32'd1);
    runCycles(FRAME_LEN);

    // Leading zeros blanked, digit 0 always shown.
    applyStimulus(16'h00A0, 4'h0, 4'h0, 1'b1);
    runCycles(2 * FRAME_LEN);

    // A decimal point stops suppression at its digit.
    applyStimulus(16'h0000, 4'b0100, 4'h0, 1'b1);
    runCycles(2 * FRAME_LEN);

    // Mid-frame change is held back until the next capture.
    applyStimulus(16'h1111, 4'h0, 4'h0, 1'b0);
    runCycles(FRAME_LEN);
    while ((cyc % FRAME_LEN) != FRAME_LEN / 2) clockStep();
    applyStimulus(16'h2222, 4'h0, 4'h0, 1'b0);
    runCycles(2 * FRAME_LEN);

    // Per-digit blanking.
    applyStimulus(16'h9876, 4'h0, 4'b0010, 1'b0);
    runCycles(2 * FRAME_LEN);

    // Random inputs changed at random points in the scan.
    for (int it = 0; it < 25; it++) begin
      applyStimulus(16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                    1'($urandom));
      runCycles($urandom_range(1, 40));
    end

    // Reset while digit 2 is lit at cnt 5.
    applyStimulus(16'h5678, 4'h0, 4'h0, 1'b0);
    runCycles(2 * FRAME_LEN);
    while (!((cyc % R) == 5 && ((cyc / R) % D) == 2)) clockStep();
    checkOutput("pre_reset_lit", 32'(bus.an), 32'h0000000B);
    rst_n = 1'b0;
    #1;
    checkOutput("async_an", 32'(bus.an), 32'h0000000F);
    checkOutput("async_seg", 32'(bus.seg), 32'h0000007F);
    checkOutput("async_dp", 32'(bus.dp), 32'd1);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    runCycles(FRAME_LEN);
    checkOutput("restart_frame", 32'(bus.frame), 32'd1);
    runCycles(2 * FRAME_LEN);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Parametrised time-multiplexed 7-segment display driver: scans DIGITS hex digits onto one shared segment bus with per-digit anode strobes. Per-digit decimal point, per-digit blanking, leading-zero suppression, anti-ghosting guard interval and frame-synchronous input capture, so values never tear mid-scan. Sits between counter/datapath logic and the board's segment/anode pins; replaces per-digit static decoders.

## Interface
- DIGITS, 4: number of digits scanned, 2..8.
- REFRESH_DIV, 100000: clk cycles per digit slot, ≥ 4.
- GUARD, 2: cycles at the start of each slot with all anodes off; 1 ≤ GUARD < REFRESH_DIV.
- SEG_ACTIVE_LOW, 1: 1 means seg/dp are driven low to light.
- AN_ACTIVE_LOW, 1: 1 means an is driven low to enable a digit.

- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- number  input  4*DIGITS  hex nibbles; nibble i = number[4i+3:4i], digit 0 rightmost.
- dp_in  input  DIGITS  decimal point request per digit.
- blank  input  DIGITS  force digit i dark.
- lz_en  input  1  enable leading-zero suppression.
- seg  output  7  segments, seg[0]=a … seg[6]=g.
- dp  output  1  decimal point segment.
- an  output  DIGITS  digit enables, one-hot when lit.
- frame  output  1  one-cycle pulse at each shadow capture.

## Operation
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..DIGITS-1), shadow registers sh_num/sh_dp/sh_blank/sh_lz.
- cnt increments every cycle; at REFRESH_DIV-1 it wraps to 0 and idx advances; idx wraps DIGITS-1 → 0.
- Capture: on the cycle cnt==REFRESH_DIV-1 and idx==DIGITS-1, shadows load from inputs and frame pulses high next cycle. Inputs are ignored at all other times.
- Glyphs (active-high segment pattern, before polarity): standard hex 0–F, with b, c, d, E, F lowercase/uppercase per the team glyph set; 0 = a..f lit, 8 = all lit.
- Leading-zero suppression: digit i (i>0) dark when sh_lz=1 and for every j ≥ i: sh_num nibble j == 0 and sh_dp[j]==0. Digit 0 never suppressed.
- Digit i lit in its slot when cnt ≥ GUARD, sh_blank[i]==0 and not suppressed. Lit: an one-hot at idx, seg=glyph, dp=sh_dp[idx]. Otherwise an, seg and dp all inactive.
- Polarity parameters invert the final registered outputs only.

## Timing
- Reset (async assert): cnt=0, idx=0, frame=0, sh_num=0, sh_dp=0, sh_blank=all 1, sh_lz=0; seg, dp and an all at inactive level. Display stays dark until the first capture, DIGITS*REFRESH_DIV cycles after release.
- Outputs are registered, one cycle behind (cnt, idx). For slot k the anode is active from cycle GUARD+1 to REFRESH_DIV of the slot, measured from the cnt==0 cycle.
- Input changes become visible only in the frame after capture. Worst-case latency is 2*DIGITS*REFRESH_DIV+1 cycles.
- Reset asserted mid-scan: outputs go inactive immediately, with no glitch to a lit state. Scanning restarts at idx 0.
- Only one anode is ever active, and never in the same cycle as a slot change.

## Structure
- Package seg_pkg: glyph constants for 0–F, SEG_OFF, and function glyph(nibble) → 7-bit active-high pattern. Shared with other display blocks.
- Sub-module seg_scan_timer: cnt/idx generator. Outputs idx, in_guard and frame_cap strobe; parameters DIGITS and REFRESH_DIV. Suppression, glyph lookup and output registers stay in the top.

## Test plan
Bench uses DIGITS=4, REFRESH_DIV=8, GUARD=2, active-low.
- Reset released with number=16'h1234 → an=4'hF, seg=7'h7F for the first 32 cycles. Frame pulses at cycle 32. The next frame shows 4,3,2,1 on an=1110,1101,1011,0111, each lit 6 of 8 cycles.
- number=16'h00A0, lz_en=1 → digits 3 and 2 dark and digit 1 shows A. Digit 0 shows 0 (seg=7'b1000000).
- number=16'h0000, lz_en=1, dp_in=4'b0100 → digit 2 shows "0." and digit 3 stays dark.
- number changes mid-frame from 16'h1111 to 16'h2222 → no digit shows 2 before the next frame pulse, then all four show 2.
- blank=4'b0010 → an[1] is never active; the other slots are unaffected.
- rst_n pulsed low at cnt=5, idx=2 → an, seg and dp go inactive in the same cycle. After release, the scan restarts at idx 0 and the display stays dark for 32 cycles.
